// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its monitor.
// Contents:
//   - light codes GREEN/YELLOW/RED (one-hot, 3 bits per light)
//   - phase numbers S1..S6 (0..5)
//   - legal light patterns, packed as {M1, M2, MT, SR}
//   - default hold parameters T1..T4, shared with the controller
//   - monitor FSM state type and the phase successor function
package tlc_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  localparam logic [2:0] S1 = 3'd0;
  localparam logic [2:0] S2 = 3'd1;
  localparam logic [2:0] S3 = 3'd2;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd4;
  localparam logic [2:0] S6 = 3'd5;

  localparam logic [11:0] PAT_S1 = {GREEN,  GREEN,  RED,    RED};
  localparam logic [11:0] PAT_S2 = {GREEN,  YELLOW, RED,    RED};
  localparam logic [11:0] PAT_S3 = {GREEN,  RED,    GREEN,  RED};
  localparam logic [11:0] PAT_S4 = {YELLOW, RED,    YELLOW, RED};
  localparam logic [11:0] PAT_S5 = {RED,    RED,    RED,    GREEN};
  localparam logic [11:0] PAT_S6 = {RED,    RED,    RED,    YELLOW};

  // Hold parameters; a phase lasts T+1 samples. Valid range 0..30.
  localparam int unsigned T1_DEF = 7;
  localparam int unsigned T2_DEF = 5;
  localparam int unsigned T3_DEF = 2;
  localparam int unsigned T4_DEF = 3;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } mon_state_e;

  // Legal successor of a phase; S6 wraps back to S1.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == S6) ? S1 : p + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus between the traffic light controller and anything watching it.
// Signals (3 bits each, one-hot light codes from tlc_pkg):
//   M1, M2  main road lights
//   MT      main road turn light
//   SR      side road light
// Modports:
//   master  the controller, drives the lights
//   slave   observers such as traffic_light_monitor
interface traffic_light_monitor_if;
  logic [2:0] M1;
  logic [2:0] M2;
  logic [2:0] MT;
  logic [2:0] SR;

  modport master (output M1, M2, MT, SR);
  modport slave  (input  M1, M2, MT, SR);
endinterface

// File: rtl/tlc_pattern_decoder.sv
// Combinational decode of a light pattern into a controller phase.
// Ports:
//   M1, M2, MT, SR  in   light codes
//   legal           out  pattern is one of the six legal phase patterns
//   phase           out  decoded phase 0..5 (S1 when not legal)
module tlc_pattern_decoder
  import tlc_pkg::*;
(
  input  logic [2:0] M1,
  input  logic [2:0] M2,
  input  logic [2:0] MT,
  input  logic [2:0] SR,
  output logic       legal,
  output logic [2:0] phase
);

  always_comb begin
    legal = 1'b1;
    phase = S1;
    case ({M1, M2, MT, SR})
      PAT_S1:  phase = S1;
      PAT_S2:  phase = S2;
      PAT_S3:  phase = S3;
      PAT_S4:  phase = S4;
      PAT_S5:  phase = S5;
      PAT_S6:  phase = S6;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light controller outputs.
// Tracks the phase sequence and checks order, dwell time and pattern legality.
// Ports:
//   clk          in   rising-edge clock shared with the controller
//   rst          in   asynchronous active-low reset
//   lights       in   light bus (slave modport), sampled every clock edge
//   clr          in   synchronous clear of err_sticky
//   phase        out  last locked phase 0..5
//   locked       out  monitor is tracking a legal phase
//   err_illegal  out  pulse: sampled pattern is illegal
//   err_order    out  pulse: phase change to a non-successor phase
//   err_dwell    out  pulse: phase held too short (underrun) or too long (overrun)
//   err_sticky   out  sticky {dwell, order, illegal}
//   round_cnt    out  completed error-free S1..S6 rounds, wraps at 255
module traffic_light_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned T1 = T1_DEF,
  parameter int unsigned T2 = T2_DEF,
  parameter int unsigned T3 = T3_DEF,
  parameter int unsigned T4 = T4_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_monitor_if.slave  lights,
  input  logic                    clr,
  output logic [2:0]              phase,
  output logic                    locked,
  output logic                    err_illegal,
  output logic                    err_order,
  output logic                    err_dwell,
  output logic [2:0]              err_sticky,
  output logic [7:0]              round_cnt
);

  localparam logic [4:0] DwellMax = 5'd31;

  // Expected number of samples for a phase.
  function automatic logic [4:0] exp_dwell(input logic [2:0] p);
    case (p)
      S1:      return 5'(T1 + 32'd1);
      S3:      return 5'(T3 + 32'd1);
      S5:      return 5'(T4 + 32'd1);
      default: return 5'(T2 + 32'd1);
    endcase
  endfunction

  logic       dec_legal;
  logic [2:0] dec_phase;

  tlc_pattern_decoder u_decoder (
    .M1    (lights.M1),
    .M2    (lights.M2),
    .MT    (lights.MT),
    .SR    (lights.SR),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  mon_state_e state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [4:0] dwell_q, dwell_d;
  logic       partial_q, partial_d;   // current phase entered mid-way, dwell unchecked
  logic       overrun_q, overrun_d;   // overrun already reported for this occupancy
  logic       clean_q, clean_d;       // round in progress is still countable
  logic       ill_q, ill_d;
  logic       ord_q, ord_d;
  logic       dwl_q, dwl_d;
  logic [2:0] sticky_q, sticky_d;
  logic [7:0] round_q, round_d;

  logic [4:0] exp_cur;
  logic [4:0] dwell_inc;

  assign exp_cur   = exp_dwell(phase_q);
  assign dwell_inc = (dwell_q == DwellMax) ? DwellMax : dwell_q + 5'd1;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    partial_d = partial_q;
    overrun_d = overrun_q;
    clean_d   = clean_q;
    round_d   = round_q;
    ill_d     = 1'b0;
    ord_d     = 1'b0;
    dwl_d     = 1'b0;

    unique case (state_q)
      StUnlocked: begin
        if (dec_legal) begin
          state_d   = StLocked;
          phase_d   = dec_phase;
          dwell_d   = 5'd1;
          partial_d = 1'b1;
          overrun_d = 1'b0;
          clean_d   = 1'b0;
        end else begin
          ill_d = 1'b1;
        end
      end

      StLocked: begin
        if (!dec_legal) begin
          ill_d   = 1'b1;
          state_d = StUnlocked;
          clean_d = 1'b0;
        end else if (dec_phase == phase_q) begin
          dwell_d = dwell_inc;
          // Compare in 6 bits so T=30 (expected 31) never reports an overrun.
          if (!overrun_q && ({1'b0, dwell_inc} == ({1'b0, exp_cur} + 6'd1))) begin
            dwl_d     = 1'b1;
            overrun_d = 1'b1;
            clean_d   = 1'b0;
          end
        end else begin
          if (dec_phase != next_phase(phase_q)) begin
            ord_d     = 1'b1;
            partial_d = 1'b1;
            clean_d   = 1'b0;
          end else begin
            partial_d = 1'b0;
            if (!partial_q && !overrun_q && (dwell_q < exp_cur)) begin
              dwl_d = 1'b1;
            end
            if (phase_q == S6) begin
              // Closing S6 ends the round; the new S1 opens a fresh one.
              if (clean_q && !partial_q && !dwl_d) begin
                round_d = round_q + 8'd1;
              end
              clean_d = 1'b1;
            end else if (dwl_d) begin
              clean_d = 1'b0;
            end
          end
          phase_d   = dec_phase;
          dwell_d   = 5'd1;
          overrun_d = 1'b0;
        end
      end

      default: state_d = StUnlocked;
    endcase

    // A pulse keeps its flag set against clr both on the edge that raises it
    // and on the edge that ends the cycle in which it is visible.
    sticky_d = (clr ? 3'b000 : sticky_q) | {dwl_d, ord_d, ill_d} | {dwl_q, ord_q, ill_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StUnlocked;
      phase_q   <= S1;
      dwell_q   <= 5'd0;
      partial_q <= 1'b0;
      overrun_q <= 1'b0;
      clean_q   <= 1'b0;
      ill_q     <= 1'b0;
      ord_q     <= 1'b0;
      dwl_q     <= 1'b0;
      sticky_q  <= 3'b000;
      round_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      partial_q <= partial_d;
      overrun_q <= overrun_d;
      clean_q   <= clean_d;
      ill_q     <= ill_d;
      ord_q     <= ord_d;
      dwl_q     <= dwl_d;
      sticky_q  <= sticky_d;
      round_q   <= round_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = (state_q == StLocked);
  assign err_illegal = ill_q;
  assign err_order   = ord_q;
  assign err_dwell   = dwl_q;
  assign err_sticky  = sticky_q;
  assign round_cnt   = round_q;

endmodule
